// File: rtl/digit_serial_pkg.sv
// Shared types and default sizing for the digit-serial add/subtract datapath.
package digit_serial_pkg;

   typedef enum logic {
      MODE_ADD = 1'b0,
      MODE_SUB = 1'b1
   } addsub_mode_e;

   localparam int DEF_DIGIT_W    = 4;
   localparam int DEF_MAX_DIGITS = 8;

endpackage

// File: rtl/digit_addsub_cell.sv
// Combinational one-digit adder with optional B inversion for subtraction.
// Reports the carries into and out of the digit MSB for signed overflow detection.
module digit_addsub_cell
   import digit_serial_pkg::*;
#(
   parameter int DIGIT_W = DEF_DIGIT_W
) (
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  addsub_mode_e       mode,
   input  logic               cin,
   output logic [DIGIT_W-1:0] s,
   output logic               c_msb_in,
   output logic               c_msb_out
);

   logic [DIGIT_W-1:0] b_eff;
   logic [DIGIT_W:0]   total;

   always_comb begin
      b_eff     = b ^ {DIGIT_W{mode == MODE_SUB}};
      total     = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
      s         = total[DIGIT_W-1:0];
      c_msb_out = total[DIGIT_W];
      // The MSB sum bit is a ^ b ^ carry-in, so the carry-in falls out without a second adder.
      c_msb_in  = s[DIGIT_W-1] ^ a[DIGIT_W-1] ^ b_eff[DIGIT_W-1];
   end

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor, LSD first, registered outputs.
// Optional word-length check enabled by defining DIGIT_SERIAL_LEN_CHECK_EN.
module digit_serial_addsub
   import digit_serial_pkg::*;
#(
   parameter int DIGIT_W    = DEF_DIGIT_W,
   parameter int MAX_DIGITS = DEF_MAX_DIGITS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               vld,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               sub,
   input  logic               last,
   output logic               out_vld,
   output logic [DIGIT_W-1:0] sum,
   output logic               out_last,
   output logic               carry_out,
   output logic               overflow,
   output logic               len_err
);

   if (DIGIT_W < 1 || MAX_DIGITS < 1) begin : g_param_check
      $error("digit_serial_addsub: DIGIT_W and MAX_DIGITS must be >= 1");
   end

   addsub_mode_e       mode_q;
   addsub_mode_e       cur_mode;
   logic               carry_q;
   logic               first_q;
   logic               cin;
   logic [DIGIT_W-1:0] s;
   logic               c_msb_in;
   logic               c_msb_out;
   logic               len_over;
   logic               accept;

   // The first digit of a word takes its mode and carry-in straight from sub.
   always_comb begin
      cur_mode = first_q ? (sub ? MODE_SUB : MODE_ADD) : mode_q;
      cin      = first_q ? sub : carry_q;
      accept   = vld & ~clr & ~len_over;
   end

   digit_addsub_cell #(
      .DIGIT_W (DIGIT_W)
   ) u_cell (
      .a         (a),
      .b         (b),
      .mode      (cur_mode),
      .cin       (cin),
      .s         (s),
      .c_msb_in  (c_msb_in),
      .c_msb_out (c_msb_out)
   );

`ifdef DIGIT_SERIAL_LEN_CHECK_EN
   localparam int                 CNT_W   = $clog2(MAX_DIGITS + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_DIGITS);

   logic [CNT_W-1:0] cnt_q;
   logic             len_err_q;

   assign len_over = (cnt_q == CNT_MAX);
   assign len_err  = len_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         len_err_q <= vld & ~clr & len_over;
         if (clr || (vld && (len_over || last))) begin
            cnt_q <= '0;
         end else if (vld) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end
`else
   assign len_over = 1'b0;
   assign len_err  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: first_q resets to 1 so the very first digit after reset starts a word.
         carry_q   <= 1'b0;
         mode_q    <= MODE_ADD;
         first_q   <= 1'b1;
         out_vld   <= 1'b0;
         sum       <= '0;
         out_last  <= 1'b0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register update on the same clock edge.
         out_vld   <= accept;
         out_last  <= accept & last;
         carry_out <= accept & last & c_msb_out;
         overflow  <= accept & last & (c_msb_in ^ c_msb_out);
         if (accept) begin
            sum <= s;
         end
         // Abort or length violation both return to word start; a last digit does too.
         if (clr || (vld && len_over)) begin
            first_q <= 1'b1;
            carry_q <= 1'b0;
         end else if (accept) begin
            mode_q  <= cur_mode;
            first_q <= last;
            carry_q <= last ? 1'b0 : c_msb_out;
         end
      end
   end

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Self-checking bench for digit_serial_addsub (DIGIT_W=4, MAX_DIGITS=4) with a scoreboard queue.
module tb_digit_serial_addsub;

   localparam int W    = 4;
   localparam int MAXD = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         clr = 1'b0;
   logic         vld = 1'b0;
   logic [W-1:0] a   = '0;
   logic [W-1:0] b   = '0;
   logic         sub = 1'b0;
   logic         last = 1'b0;
   logic         out_vld;
   logic [W-1:0] sum;
   logic         out_last;
   logic         carry_out;
   logic         overflow;
   logic         len_err;

   digit_serial_addsub #(
      .DIGIT_W    (W),
      .MAX_DIGITS (MAXD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .vld       (vld),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .last      (last),
      .out_vld   (out_vld),
      .sum       (sum),
      .out_last  (out_last),
      .carry_out (carry_out),
      .overflow  (overflow),
      .len_err   (len_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         last;
      logic         cout;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic         last;
      int           gap;
      logic [W-1:0] e_sum;
      logic         e_cout;
      logic         e_ovf;
   } vec_t;

   exp_t q[$];
   vec_t vecs[$];
   int   n_vec = 0;
   int   n_miss = 0;
   int   len_err_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every result digit must match the oldest pending expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (len_err) len_err_seen++;
         if (out_vld) begin
            if (q.size() == 0) begin
               check("unexpected_out_vld", {31'b0, out_vld}, 32'd0);
            end else begin
               e = q.pop_front();
               check("sum", {28'b0, sum}, {28'b0, e.sum});
               check("out_last", {31'b0, out_last}, {31'b0, e.last});
               check("carry_out", {31'b0, carry_out}, {31'b0, e.cout});
               check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
            end
         end else begin
            check("idle_flags", {29'b0, out_last, carry_out, overflow}, 32'd0);
         end
      end
   end

   task automatic apply(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si,
                        input logic li, input logic [W-1:0] es, input logic ec,
                        input logic eo, input bit push);
      exp_t e;
      a    = ai;
      b    = bi;
      sub  = si;
      last = li;
      vld  = 1'b1;
      e = '{sum: es, last: li, cout: li & ec, ovf: li & eo};
      if (push) q.push_back(e);
      @(posedge clk);
      #1;
      vld  = 1'b0;
      last = 1'b0;
      sub  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clr_cycle();
      clr  = 1'b1;
      vld  = 1'b1;
      a    = 4'h9;
      b    = 4'h9;
      last = 1'b1;
      @(posedge clk);
      #1;
      clr  = 1'b0;
      vld  = 1'b0;
      last = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      //              a     b     sub   last gap sum   cout  ovf
      vecs.push_back('{4'h5, 4'h7, 1'b0, 1'b0, 0, 4'hC, 1'b0, 1'b0});
      vecs.push_back('{4'h3, 4'h1, 1'b0, 1'b1, 0, 4'h4, 1'b0, 1'b0});
      vecs.push_back('{4'h0, 4'h1, 1'b1, 1'b0, 0, 4'hF, 1'b0, 1'b0});
      vecs.push_back('{4'h1, 4'h0, 1'b0, 1'b1, 0, 4'h0, 1'b1, 1'b0});
      vecs.push_back('{4'hF, 4'h1, 1'b0, 1'b0, 0, 4'h0, 1'b0, 1'b0});
      vecs.push_back('{4'h7, 4'h0, 1'b0, 1'b1, 0, 4'h8, 1'b0, 1'b1});
      vecs.push_back('{4'h5, 4'h7, 1'b0, 1'b0, 2, 4'hC, 1'b0, 1'b0});
      vecs.push_back('{4'h3, 4'h1, 1'b0, 1'b1, 0, 4'h4, 1'b0, 1'b0});
      vecs.push_back('{4'h0, 4'h1, 1'b1, 1'b0, 2, 4'hF, 1'b0, 1'b0});
      vecs.push_back('{4'h1, 4'h0, 1'b0, 1'b1, 1, 4'h0, 1'b1, 1'b0});
      vecs.push_back('{4'h7, 4'h1, 1'b0, 1'b1, 0, 4'h8, 1'b0, 1'b1});
      vecs.push_back('{4'h3, 4'h5, 1'b1, 1'b1, 0, 4'hE, 1'b0, 1'b0});
      vecs.push_back('{4'h8, 4'h1, 1'b1, 1'b1, 0, 4'h7, 1'b1, 1'b1});
      vecs.push_back('{4'h0, 4'h1, 1'b0, 1'b0, 0, 4'h1, 1'b0, 1'b0});
      vecs.push_back('{4'h1, 4'h0, 1'b1, 1'b1, 0, 4'h1, 1'b0, 1'b0});
      vecs.push_back('{4'hF, 4'hF, 1'b0, 1'b0, 0, 4'hE, 1'b0, 1'b0});
      vecs.push_back('{4'hF, 4'hF, 1'b0, 1'b0, 0, 4'hF, 1'b0, 1'b0});
      vecs.push_back('{4'hF, 4'hF, 1'b0, 1'b0, 0, 4'hF, 1'b0, 1'b0});
      vecs.push_back('{4'hF, 4'hF, 1'b0, 1'b1, 0, 4'hF, 1'b1, 1'b0});

      #12;
      check("reset_outputs", {23'b0, out_vld, out_last, carry_out, overflow, len_err, sum}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].last,
               vecs[i].e_sum, vecs[i].e_cout, vecs[i].e_ovf, 1'b1);
         idle(vecs[i].gap);
      end

      // Abort mid-word: the clr cycle's digit is dropped and no stale carry survives.
      apply(4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
      clr_cycle();
      apply(4'h5, 4'h7, 1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1);
      idle(1);

      // Asynchronous reset mid-word clears outputs before the next clock edge.
      apply(4'hE, 4'h3, 1'b0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("async_rst_outputs", {23'b0, out_vld, out_last, carry_out, overflow, len_err, sum}, 32'd0);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      apply(4'h5, 4'h7, 1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1);

      // Over-length word: five digits, no last.
      len_err_seen = 0;
`ifdef DIGIT_SERIAL_LEN_CHECK_EN
      for (int i = 0; i < 5; i++) begin
         apply(4'h1, 4'h1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, i < MAXD);
      end
      idle(2);
      check("len_err_pulses", len_err_seen, 32'd1);
`else
      for (int i = 0; i < 5; i++) begin
         apply(4'h1, 4'h1, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0, 1'b1);
      end
      idle(2);
      check("len_err_pulses", len_err_seen, 32'd0);
      clr_cycle();
`endif
      apply(4'h5, 4'h7, 1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 1'b1);
      apply(4'h3, 4'h1, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1);

      idle(3);
      check("scoreboard_drain", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
